// File: rtl/palette_arb_pkg.sv
// Shared types and default sizing for the palette RAM arbiter and its write buffer.
package palette_arb_pkg;

  localparam int ADDR_W_DEFAULT     = 8;
  localparam int DATA_W_DEFAULT     = 8;
  localparam int FIFO_DEPTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    RD_ISSUE,
    RD_WAIT
  } arb_state_e;

  typedef struct packed {
    logic [ADDR_W_DEFAULT-1:0] addr;
    logic [DATA_W_DEFAULT-1:0] data;
  } wr_entry_t;

endpackage

// File: rtl/palette_wr_fifo.sv
// Small synchronous FIFO buffering CPU palette writes until the next blanking interval.
module palette_wr_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  // NOTE: storage is deliberately not reset; count gates every use, so stale entries are never observed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/palette_ram_arbiter.sv
// Shares the single-port palette RAM between video lookups (active display) and
// buffered CPU writes / coherent CPU reads (blanking only).
module palette_ram_arbiter
  import palette_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEFAULT,
  parameter int DATA_W     = DATA_W_DEFAULT,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              blank,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_data,
  output logic              vid_valid,
  input  logic              cpu_wr_req,
  output logic              cpu_wr_ack,
  input  logic              cpu_rd_req,
  output logic              cpu_rd_ack,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              fifo_full,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  arb_state_e        state;
  entry_t            push_entry;
  entry_t            head;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic              push;
  logic              pop;
  logic              wr_ack_q;
  logic              rd_pending;
  logic              rd_ack_q;
  logic              vid_valid_q;
  logic [DATA_W-1:0] rdata_q;

  // A held request is accepted once; an outstanding read blocks writes so it cannot be overtaken.
  assign push       = cpu_wr_req & ~fifo_full & ~rd_pending & ~wr_ack_q;
  assign pop        = (state == DRAIN) & blank & ~fifo_empty;
  assign push_entry = '{addr: cpu_addr, data: cpu_wdata};

  palette_wr_fifo #(
    .WIDTH($bits(entry_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_wr_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .din  (push_entry),
    .head (head),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      wr_ack_q    <= 1'b0;
      rd_pending  <= 1'b0;
      rd_ack_q    <= 1'b0;
      vid_valid_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      wr_ack_q    <= push;
      rd_pending  <= cpu_rd_req & ~rd_ack_q;
      vid_valid_q <= ~blank;
      rd_ack_q    <= 1'b0;
      unique case (state)
        IDLE: begin
          // Buffered (or just-accepted) writes always retire before any read issues.
          if (blank && (!fifo_empty || push)) state <= DRAIN;
          else if (blank && cpu_rd_req)       state <= RD_ISSUE;
        end
        DRAIN: begin
          if (!blank || fifo_empty || (fifo_count == CNT_W'(1) && !push)) state <= IDLE;
        end
        RD_ISSUE: begin
          if (blank) begin
            state    <= RD_WAIT;
            rd_ack_q <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        RD_WAIT: begin
          rdata_q <= ram_rdata;
          state   <= IDLE;
        end
      endcase
    end
  end

  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    ram_addr = vid_addr;
    ram_we   = 1'b0;
    if (blank) begin
      if (state == DRAIN) begin
        ram_addr = head.addr;
        ram_we   = ~fifo_empty;
      end else if (state == RD_ISSUE) begin
        ram_addr = cpu_addr;
      end
    end
  end

  assign ram_wdata  = head.data;
  assign cpu_wr_ack = push;
  assign cpu_rd_ack = rd_ack_q;
  // The RAM returns read data in the ack cycle itself, so bypass the holding register then.
  assign cpu_rdata  = rd_ack_q ? ram_rdata : rdata_q;
  assign vid_valid  = vid_valid_q;
  assign vid_data   = vid_valid_q ? ram_rdata : '0;

endmodule

// File: tb/tb_palette_ram_arbiter.sv
// Directed bench for palette_ram_arbiter with a behavioural 256x8 synchronous palette RAM.
module tb_palette_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       blank;
  logic [7:0] vid_addr;
  logic [7:0] vid_data;
  logic       vid_valid;
  logic       cpu_wr_req;
  logic       cpu_wr_ack;
  logic       cpu_rd_req;
  logic       cpu_rd_ack;
  logic [7:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic [7:0] cpu_rdata;
  logic       fifo_full;
  logic [7:0] ram_addr;
  logic       ram_we;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata;

  palette_ram_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .blank     (blank),
    .vid_addr  (vid_addr),
    .vid_data  (vid_data),
    .vid_valid (vid_valid),
    .cpu_wr_req(cpu_wr_req),
    .cpu_wr_ack(cpu_wr_ack),
    .cpu_rd_req(cpu_rd_req),
    .cpu_rd_ack(cpu_rd_ack),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .fifo_full (fifo_full),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] preload(input logic [7:0] a);
    return (a * 8'd3) ^ 8'h5C;
  endfunction

  // Palette RAM: unwritten locations read back their preload pattern.
  logic [7:0] ram [256];
  bit         written [256];
  always @(posedge clk) begin
    if (ram_we) begin
      ram[ram_addr]     <= ram_wdata;
      written[ram_addr] <= 1'b1;
    end
    ram_rdata <= written[ram_addr] ? ram[ram_addr] : preload(ram_addr);
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rd_ack(input int budget, output bit seen);
    seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge clk);
      if (cpu_rd_ack) seen = 1'b1;
      else tick();
    end
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    cpu_addr   = a;
    cpu_wdata  = d;
    cpu_wr_req = 1'b1;
    @(negedge clk);
    check($sformatf("push 0x%0h ack", a), cpu_wr_ack, 1);
    tick();
    cpu_wr_req = 1'b0;
    tick();
  endtask

  task automatic do_read(input logic [7:0] a, input logic [7:0] exp);
    bit seen;
    cpu_addr   = a;
    cpu_rd_req = 1'b1;
    wait_rd_ack(8, seen);
    check($sformatf("read 0x%0h ack seen", a), seen, 1);
    check($sformatf("read 0x%0h data", a), cpu_rdata, exp);
    tick();
    cpu_rd_req = 1'b0;
    tick();
  endtask

  typedef struct {
    logic       blank;
    logic       wr_req;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       ack;
    logic       full;
    logic       we;
    logic [7:0] exp_addr;
    logic [7:0] exp_wdata;
  } vec_t;

  vec_t vecs [23];

  function automatic vec_t mk(input logic b, input logic r, input logic [7:0] a, input logic [7:0] d,
                              input logic ack, input logic full, input logic we,
                              input logic [7:0] ea, input logic [7:0] ed);
    return '{b, r, a, d, ack, full, we, ea, ed};
  endfunction

  initial begin
    bit   seen;
    int   we_seen;
    int   ack_seen;
    logic prev_blank;

    // Write 0x42<-0xA5 in active display, then drain it in blanking.
    vecs[0]  = mk(0, 1, 8'h42, 8'hA5, 1, 0, 0, 8'h07, 8'h00);
    vecs[1]  = mk(0, 0, 8'h42, 8'hA5, 0, 0, 0, 8'h07, 8'h00);
    vecs[2]  = mk(1, 0, 8'h42, 8'hA5, 0, 0, 0, 8'h00, 8'h00);
    vecs[3]  = mk(1, 0, 8'h42, 8'hA5, 0, 0, 1, 8'h42, 8'hA5);
    vecs[4]  = mk(1, 0, 8'h42, 8'hA5, 0, 0, 0, 8'h00, 8'h00);
    vecs[5]  = mk(0, 0, 8'h42, 8'hA5, 0, 0, 0, 8'h07, 8'h00);
    // Five writes into a depth-4 buffer; the fifth is acked the cycle after the first pop.
    vecs[6]  = mk(0, 1, 8'h01, 8'h11, 1, 0, 0, 8'h07, 8'h00);
    vecs[7]  = mk(0, 0, 8'h01, 8'h11, 0, 0, 0, 8'h07, 8'h00);
    vecs[8]  = mk(0, 1, 8'h02, 8'h22, 1, 0, 0, 8'h07, 8'h00);
    vecs[9]  = mk(0, 0, 8'h02, 8'h22, 0, 0, 0, 8'h07, 8'h00);
    vecs[10] = mk(0, 1, 8'h03, 8'h33, 1, 0, 0, 8'h07, 8'h00);
    vecs[11] = mk(0, 0, 8'h03, 8'h33, 0, 0, 0, 8'h07, 8'h00);
    vecs[12] = mk(0, 1, 8'h04, 8'h44, 1, 0, 0, 8'h07, 8'h00);
    vecs[13] = mk(0, 0, 8'h04, 8'h44, 0, 1, 0, 8'h07, 8'h00);
    vecs[14] = mk(0, 1, 8'h05, 8'h55, 0, 1, 0, 8'h07, 8'h00);
    vecs[15] = mk(1, 1, 8'h05, 8'h55, 0, 1, 0, 8'h00, 8'h00);
    vecs[16] = mk(1, 1, 8'h05, 8'h55, 0, 1, 1, 8'h01, 8'h11);
    vecs[17] = mk(1, 1, 8'h05, 8'h55, 1, 0, 1, 8'h02, 8'h22);
    vecs[18] = mk(1, 0, 8'h05, 8'h55, 0, 0, 1, 8'h03, 8'h33);
    vecs[19] = mk(1, 0, 8'h05, 8'h55, 0, 0, 1, 8'h04, 8'h44);
    vecs[20] = mk(1, 0, 8'h05, 8'h55, 0, 0, 1, 8'h05, 8'h55);
    vecs[21] = mk(1, 0, 8'h05, 8'h55, 0, 0, 0, 8'h00, 8'h00);
    vecs[22] = mk(0, 0, 8'h05, 8'h55, 0, 0, 0, 8'h07, 8'h00);

    rst        = 1'b1;
    blank      = 1'b0;
    vid_addr   = 8'h00;
    cpu_wr_req = 1'b0;
    cpu_rd_req = 1'b0;
    cpu_addr   = 8'h00;
    cpu_wdata  = 8'h00;

    // Reset state.
    repeat (2) tick();
    @(negedge clk);
    check("rst fifo_full", fifo_full, 0);
    check("rst wr_ack", cpu_wr_ack, 0);
    check("rst rd_ack", cpu_rd_ack, 0);
    check("rst cpu_rdata", cpu_rdata, 0);
    check("rst vid_valid", vid_valid, 0);
    check("rst vid_data", vid_data, 0);
    tick();
    rst = 1'b0;
    repeat (2) tick();

    // Video sweep over the whole palette, one cycle of latency, no RAM writes.
    we_seen = 0;
    for (int i = 0; i <= 256; i++) begin
      vid_addr = 8'(i);
      @(negedge clk);
      if (ram_we) we_seen++;
      if (i > 0) check($sformatf("sweep vid_data[0x%0h]", i - 1), vid_data, preload(8'(i - 1)));
      tick();
    end
    check("sweep ram_we pulses", we_seen, 0);

    // Table-driven write / FIFO-full / drain sequence.
    vid_addr   = 8'h07;
    prev_blank = 1'b0;
    for (int i = 0; i < 23; i++) begin
      blank      = vecs[i].blank;
      cpu_wr_req = vecs[i].wr_req;
      cpu_addr   = vecs[i].addr;
      cpu_wdata  = vecs[i].wdata;
      @(negedge clk);
      check($sformatf("v%0d wr_ack", i), cpu_wr_ack, vecs[i].ack);
      check($sformatf("v%0d fifo_full", i), fifo_full, vecs[i].full);
      check($sformatf("v%0d ram_we", i), ram_we, vecs[i].we);
      check($sformatf("v%0d vid_valid", i), vid_valid, !prev_blank);
      if (!vecs[i].blank || vecs[i].we) check($sformatf("v%0d ram_addr", i), ram_addr, vecs[i].exp_addr);
      if (vecs[i].we) check($sformatf("v%0d ram_wdata", i), ram_wdata, vecs[i].exp_wdata);
      prev_blank = vecs[i].blank;
      tick();
    end
    cpu_wr_req = 1'b0;

    // Read with an empty FIFO in blanking: ack two cycles after the request.
    blank = 1'b1;
    tick();
    cpu_addr   = 8'h42;
    cpu_rd_req = 1'b1;
    @(negedge clk);
    check("rd42 ack N", cpu_rd_ack, 0);
    tick();
    @(negedge clk);
    check("rd42 issue ram_addr", ram_addr, 8'h42);
    check("rd42 ack N+1", cpu_rd_ack, 0);
    tick();
    @(negedge clk);
    check("rd42 ack N+2", cpu_rd_ack, 1);
    check("rd42 data", cpu_rdata, 8'hA5);
    tick();
    cpu_rd_req = 1'b0;
    @(negedge clk);
    check("rd42 ack drops", cpu_rd_ack, 0);
    check("rd42 data held", cpu_rdata, 8'hA5);
    tick();

    // Same-cycle write and read to 0x10: write first, then a coherent read.
    cpu_addr   = 8'h10;
    cpu_wdata  = 8'h33;
    cpu_wr_req = 1'b1;
    cpu_rd_req = 1'b1;
    @(negedge clk);
    check("raw wr_ack", cpu_wr_ack, 1);
    tick();
    cpu_wr_req = 1'b0;
    @(negedge clk);
    check("raw ram_we", ram_we, 1);
    check("raw ram_addr", ram_addr, 8'h10);
    check("raw ram_wdata", ram_wdata, 8'h33);
    tick();
    wait_rd_ack(8, seen);
    check("raw rd_ack seen", seen, 1);
    check("raw rdata", cpu_rdata, 8'h33);
    tick();
    cpu_rd_req = 1'b0;
    tick();

    // Read issued one cycle before blank falls: aborted, then completes on the next blank.
    cpu_addr   = 8'h03;
    cpu_rd_req = 1'b1;
    @(negedge clk);
    check("abort ack N", cpu_rd_ack, 0);
    tick();
    blank = 1'b0;
    @(negedge clk);
    check("abort ack N+1", cpu_rd_ack, 0);
    check("abort ram_we", ram_we, 0);
    check("abort ram_addr", ram_addr, 8'h07);
    tick();
    ack_seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (cpu_rd_ack) ack_seen++;
      tick();
    end
    check("abort no ack in display", ack_seen, 0);
    blank = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("reissue ack B+%0d", k), cpu_rd_ack, (k == 2));
      if (k == 2) check("reissue data", cpu_rdata, 8'h33);
      tick();
    end
    cpu_rd_req = 1'b0;
    tick();

    // Reset while draining three queued writes.
    blank = 1'b0;
    tick();
    do_write(8'h80, 8'hE0);
    do_write(8'h81, 8'hE1);
    do_write(8'h82, 8'hE2);
    blank = 1'b1;
    tick();
    @(negedge clk);
    check("drain ram_we before rst", ram_we, 1);
    check("drain ram_addr before rst", ram_addr, 8'h80);
    #1 rst = 1'b1;
    #1;
    check("mid rst fifo_full", fifo_full, 0);
    check("mid rst ram_we", ram_we, 0);
    check("mid rst wr_ack", cpu_wr_ack, 0);
    check("mid rst rd_ack", cpu_rd_ack, 0);
    tick();
    rst = 1'b0;
    we_seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (ram_we) we_seen++;
      tick();
    end
    check("post rst ram_we pulses", we_seen, 0);
    do_read(8'h80, preload(8'h80));
    do_read(8'h82, preload(8'h82));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
